// File: rtl/ddr_pkg.sv
// Shared types for the DDR arbiter: FSM states, requester IDs and width defaults.
package ddr_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_BLK_W  = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    function automatic req_id_t onehot_to_id(input logic [1:0] oh);
        return (oh == 2'b10) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/ddr_arbiter_rr_arb2.sv
// Two-way round-robin decision: grants the side not served last when both request.
module rr_arb2
    import ddr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    req_id_t last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == REQ_I) ? 2'b10 : 2'b01;
        end
    end

    // Pointer starts on the data side so the instruction side wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= REQ_D;
        end else if (update) begin
            last <= onehot_to_id(grant);
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// Arbitrates instruction- and data-side block requests onto a single DDR controller port.
module ddr_arbiter
    import ddr_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLK_W   = DEF_BLK_W,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic              i_ack,
    output logic              d_ack,
    output logic [BLK_W-1:0]  rdata,
    output logic              err,
    output logic              ram_en,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BLK_W-1:0]  data_to_ram,
    input  logic              ram_rdy,
    input  logic [BLK_W-1:0]  block_out
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    req_id_t           owner;
    req_id_t           winner;
    logic [CNT_W-1:0]  busy_cnt;
    logic [1:0]        grant;
    logic              take;

    assign take   = (state == ST_IDLE) && (i_req || d_req);
    assign winner = onehot_to_id(grant);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_req, i_req}),
        .update (take),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= REQ_I;
            busy_cnt    <= '0;
            ram_en      <= 1'b0;
            ram_write   <= 1'b0;
            ram_addr    <= '0;
            data_to_ram <= '0;
            rdata       <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            err         <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner       <= winner;
                        ram_en      <= 1'b1;
                        ram_write   <= (winner == REQ_D) && d_we;
                        ram_addr    <= (winner == REQ_D) ? d_addr : i_addr;
                        data_to_ram <= (winner == REQ_D) ? d_wdata : '0;
                        busy_cnt    <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A completion on the final permitted cycle still counts as a normal completion.
                    if (ram_rdy || busy_cnt == CNT_LAST) begin
                        if (ram_rdy) begin
                            rdata <= block_out;
                        end else begin
                            err <= 1'b1;
                        end
                        i_ack  <= (owner == REQ_I);
                        d_ack  <= (owner == REQ_D);
                        ram_en <= 1'b0;
                        state  <= ST_GAP;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    ram_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: directed vector table, corner sequences, and random traffic vs a reference model.
module tb_ddr_arbiter;

    localparam int AW = 30;
    localparam int BW = 256;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, ram_rdy = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [BW-1:0] d_wdata = '0, block_out = '0;
    logic          i_ack, d_ack, err, ram_en, ram_write;
    logic [BW-1:0] rdata, data_to_ram;
    logic [AW-1:0] ram_addr;

    ddr_arbiter #(.ADDR_W(AW), .BLK_W(BW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .i_addr(i_addr), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .i_ack(i_ack), .d_ack(d_ack), .rdata(rdata), .err(err),
        .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .data_to_ram(data_to_ram),
        .ram_rdy(ram_rdy), .block_out(block_out)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: transaction phase, age of the current transaction, last served side.
    int            m_phase = 0;
    int            m_age   = 0;
    bit            m_last  = 1'b1;
    bit            m_side  = 1'b0;
    logic          e_en = 0, e_wr = 0, e_iack = 0, e_dack = 0, e_err = 0;
    logic [AW-1:0] e_addr = '0;
    logic [BW-1:0] e_wdata = '0, e_rdata = '0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_last = 1'b1;
            e_en = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
            e_iack = 0; e_dack = 0; e_err = 0; e_rdata = '0;
        end else begin
            e_iack = 0; e_dack = 0; e_err = 0;
            if (m_phase == 0) begin
                if (i_req || d_req) begin
                    m_side  = (i_req && d_req) ? !m_last : d_req;
                    m_last  = m_side;
                    e_en    = 1;
                    e_wr    = m_side && d_we;
                    e_addr  = m_side ? d_addr : i_addr;
                    e_wdata = m_side ? d_wdata : '0;
                    m_age   = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_age++;
                if (ram_rdy || m_age == TO) begin
                    if (ram_rdy) e_rdata = block_out;
                    else e_err = 1;
                    e_iack  = !m_side;
                    e_dack  = m_side;
                    e_en    = 0;
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("m_ram_en", ram_en, e_en);
        check("m_ram_write", ram_write, e_wr);
        check("m_ram_addr", ram_addr, e_addr);
        check("m_data_to_ram", data_to_ram, e_wdata);
        check("m_i_ack", i_ack, e_iack);
        check("m_d_ack", d_ack, e_dack);
        check("m_err", err, e_err);
        check("m_rdata", rdata, e_rdata);
    endtask

    typedef struct {
        int            n;
        bit            rst, ireq, dreq, we, rdy;
        logic [AW-1:0] iaddr, daddr;
        logic [7:0]    wb, bb;
        bit            en, wr, iack, dack, er;
        logic [AW-1:0] addr;
        logic [7:0]    rb;
    } vec_t;

    vec_t tbl[15];

    initial begin
        //            n  rst   ireq  dreq  we    rdy   iaddr      daddr      wb     bb     en    wr    iack  dack  er    addr       rb
        tbl[0]  = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h000, 30'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h000, 8'h00};
        tbl[1]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'h100, 30'h000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h100, 8'h00};
        tbl[2]  = '{8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'h100, 30'h000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h100, 8'h00};
        tbl[3]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h100, 30'h000, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h100, 8'hA5};
        tbl[4]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'h100, 30'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h100, 8'hA5};
        tbl[5]  = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 30'h000, 30'h000, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h100, 8'hA5};
        tbl[6]  = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h000, 30'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h000, 8'h00};
        tbl[7]  = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 30'h140, 30'h200, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h140, 8'h00};
        tbl[8]  = '{2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 30'h140, 30'h200, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h140, 8'h00};
        tbl[9]  = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 30'h140, 30'h200, 8'h5A, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h140, 8'h11};
        tbl[10] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h000, 30'h200, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h140, 8'h11};
        tbl[11] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h000, 30'h200, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'h200, 8'h11};
        tbl[12] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h000, 30'h200, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'h200, 8'h11};
        tbl[13] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 30'h000, 30'h200, 8'h5A, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h200, 8'h22};
        tbl[14] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h000, 30'h000, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'h200, 8'h22};

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; i_req = tbl[i].ireq; d_req = tbl[i].dreq; d_we = tbl[i].we;
            ram_rdy = tbl[i].rdy; i_addr = tbl[i].iaddr; d_addr = tbl[i].daddr;
            d_wdata = {32{tbl[i].wb}}; block_out = {32{tbl[i].bb}};
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                check($sformatf("v%0d_ram_en", i), ram_en, tbl[i].en);
                check($sformatf("v%0d_ram_write", i), ram_write, tbl[i].wr);
                check($sformatf("v%0d_i_ack", i), i_ack, tbl[i].iack);
                check($sformatf("v%0d_d_ack", i), d_ack, tbl[i].dack);
                check($sformatf("v%0d_err", i), err, tbl[i].er);
                check($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].addr);
                check($sformatf("v%0d_rdata", i), rdata, {32{tbl[i].rb}});
                check($sformatf("v%0d_data_to_ram", i), data_to_ram, tbl[i].wr ? {32{tbl[i].wb}} : '0);
            end
        end
        rst = 0; i_req = 0; d_req = 0; d_we = 0; ram_rdy = 0;

        // Fairness: both sides held, four transactions served I, D, I, D, acks three cycles apart.
        begin
            int order[$];
            int ack_cyc[$];
            int cyc = 0;
            rst = 1; tick(); rst = 0;
            i_req = 1; d_req = 1; i_addr = 30'h10; d_addr = 30'h20;
            while (order.size() < 4 && cyc < 200) begin
                tick();
                cyc++;
                if (i_ack || d_ack) begin
                    order.push_back(d_ack ? 1 : 0);
                    ack_cyc.push_back(cyc);
                end
                ram_rdy = ram_en;
            end
            check("fair_count", order.size(), 4);
            for (int k = 0; k < order.size(); k++) begin
                check($sformatf("fair_side%0d", k), order[k], k % 2);
                if (k > 0) check($sformatf("fair_spacing%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
            end
            i_req = 0; d_req = 0; ram_rdy = 0;
            tick(); tick();
        end

        // Timeout: data read granted, no completion ever arrives.
        begin
            int n_en = 0;
            rst = 1; tick(); rst = 0;
            d_req = 1; d_we = 0; d_addr = 30'h300;
            tick();
            while (ram_en && n_en < 40) begin
                n_en++;
                tick();
            end
            check("to_busy_cycles", n_en, TO);
            check("to_d_ack", d_ack, 1'b1);
            check("to_err", err, 1'b1);
            check("to_ram_en", ram_en, 1'b0);
            d_req = 0;
            tick(); tick();
        end

        // Reset mid-transaction abandons it; the instruction side then wins a tie.
        rst = 1; tick(); rst = 0;
        d_req = 1; d_we = 1; d_addr = 30'h340;
        tick();
        repeat (4) tick();
        rst = 1;
        tick();
        check("rstmid_ram_en", ram_en, 1'b0);
        check("rstmid_d_ack", d_ack, 1'b0);
        rst = 0; i_req = 1; i_addr = 30'h44;
        tick();
        check("rstmid_regrant_en", ram_en, 1'b1);
        check("rstmid_regrant_addr", ram_addr, 30'h44);
        check("rstmid_regrant_write", ram_write, 1'b0);
        i_req = 0; d_req = 0;
        ram_rdy = 1; tick(); ram_rdy = 0;
        tick(); tick();

        // A request dropped while granted is still acknowledged.
        i_req = 1; i_addr = 30'h55;
        tick();
        i_req = 0;
        repeat (3) tick();
        ram_rdy = 1; block_out = {8{32'hCAFE_0055}};
        tick();
        check("withdraw_i_ack", i_ack, 1'b1);
        check("withdraw_rdata", rdata, {8{32'hCAFE_0055}});
        ram_rdy = 0;
        tick();

        // Random traffic against the model.
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            i_req   = ($urandom_range(0, 9) < 6);
            d_req   = ($urandom_range(0, 9) < 6);
            d_we    = $urandom_range(0, 1) == 1;
            i_addr  = AW'($urandom);
            d_addr  = AW'($urandom);
            for (int w = 0; w < BW / 32; w++) begin
                d_wdata[w*32 +: 32]   = $urandom;
                block_out[w*32 +: 32] = $urandom;
            end
            ram_rdy = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
